// File: rtl/magcmp_pkg.sv
// Shared relation encoding for the magnitude-compare debouncer.
package magcmp_pkg;

    typedef logic [1:0] rel_t;

    localparam rel_t REL_UNK = 2'b00;
    localparam rel_t REL_EQ  = 2'b01;
    localparam rel_t REL_GT  = 2'b10;
    localparam rel_t REL_LT  = 2'b11;

    // Run counter must hold the largest legal debounce length (15).
    localparam int CNT_W = 4;

    function automatic rel_t rel_encode(input logic eq, input logic gt, input logic lt);
        rel_t r;
        r = REL_UNK;
        if (eq)      r = REL_EQ;
        else if (gt) r = REL_GT;
        else if (lt) r = REL_LT;
        return r;
    endfunction

endpackage

// File: rtl/mag_comparator.sv
// Combinational unsigned magnitude comparator with one-hot eq/gt/lt flags.
module mag_comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/magcmp_debounce.sv
// Two-stage compare/debounce: registered raw relation, then run-length debounce.
// Optional saturating change counter on evt_count when MAGCMP_DBNC_EVTCNT_EN is defined.
module magcmp_debounce
    import magcmp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DBNC_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       stable_rel,
    output logic             chg_pulse,
    output logic [1:0]       raw_rel
`ifdef MAGCMP_DBNC_EVTCNT_EN
    ,
    output logic [7:0]       evt_count
`endif
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(DBNC_LEN);

    logic cmp_eq, cmp_gt, cmp_lt;
    rel_t cmp_rel;

    rel_t             raw_rel_q, raw_rel_d;
    logic             raw_vld_q, raw_vld_d;
    rel_t             cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rel_t             stable_q, stable_d;
    logic             pulse_q, pulse_d;

    mag_comparator #(.WIDTH(WIDTH)) u_cmp (
        .a_i  (a),
        .b_i  (b),
        .eq_o (cmp_eq),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt)
    );

    assign cmp_rel = rel_encode(cmp_eq, cmp_gt, cmp_lt);

    always_comb begin
        raw_rel_d = raw_rel_q;
        raw_vld_d = 1'b0;
        if (clr) begin
            raw_rel_d = REL_UNK;
        end else if (in_valid) begin
            raw_rel_d = cmp_rel;
            raw_vld_d = 1'b1;
        end
    end

    // Idle cycles (raw_vld_q low) freeze the run so gaps neither break nor extend it.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        if (clr) begin
            cand_d   = REL_UNK;
            cnt_d    = '0;
            stable_d = REL_UNK;
        end else if (raw_vld_q) begin
            if (raw_rel_q == cand_q) begin
                if (cnt_q < LEN_C) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_d = raw_rel_q;
                cnt_d  = CNT_W'(1);
            end
            if ((cnt_d == LEN_C) && (cand_d != stable_q) && (cand_d != REL_UNK)) begin
                stable_d = cand_d;
                pulse_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_rel_q <= REL_UNK;
            raw_vld_q <= 1'b0;
            cand_q    <= REL_UNK;
            cnt_q     <= '0;
            stable_q  <= REL_UNK;
            pulse_q   <= 1'b0;
        end else begin
            raw_rel_q <= raw_rel_d;
            raw_vld_q <= raw_vld_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            pulse_q   <= pulse_d;
        end
    end

    assign stable_rel = stable_q;
    assign chg_pulse  = pulse_q;
    assign raw_rel    = raw_rel_q;

`ifdef MAGCMP_DBNC_EVTCNT_EN
    logic [7:0] evt_q, evt_d;

    always_comb begin
        evt_d = evt_q;
        if (clr)                             evt_d = '0;
        else if (pulse_d && evt_q != 8'hFF)  evt_d = evt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) evt_q <= '0;
        else     evt_q <= evt_d;
    end

    assign evt_count = evt_q;
`endif

endmodule

// File: tb/tb_magcmp_debounce.sv
// Bench for magcmp_debounce: directed vector table, async reset, clear collision, random vs. history model.
module tb_magcmp_debounce;
    import magcmp_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid;
    logic [3:0] a, b;
    logic [1:0] st0, raw0, st1, raw1;
    logic       p0, p1;
`ifdef MAGCMP_DBNC_EVTCNT_EN
    logic [7:0] ev0, ev1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    magcmp_debounce #(.WIDTH(4), .DBNC_LEN(3)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b),
        .stable_rel(st0), .chg_pulse(p0), .raw_rel(raw0)
`ifdef MAGCMP_DBNC_EVTCNT_EN
        , .evt_count(ev0)
`endif
    );

    magcmp_debounce #(.WIDTH(4), .DBNC_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b),
        .stable_rel(st1), .chg_pulse(p1), .raw_rel(raw1)
`ifdef MAGCMP_DBNC_EVTCNT_EN
        , .evt_count(ev1)
`endif
    );

    // Reference model: stable relation changes to r when the last N delivered samples are all r.
    logic [1:0] m_raw;
    logic       m_raw_vld;
    logic [1:0] m_st[2];
    logic       m_p[2];
    int         m_ev[2];
    logic [1:0] m_h[2][16];
    int         m_hn[2];

    function automatic int nlen(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic logic [1:0] rel_of(input int x, input int y);
        if (x == y) return REL_EQ;
        if (x > y)  return REL_GT;
        return REL_LT;
    endfunction

    task automatic model_reset();
        m_raw = REL_UNK;
        m_raw_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = REL_UNK; m_p[k] = 1'b0; m_ev[k] = 0; m_hn[k] = 0;
        end
    endtask

    task automatic model_edge(input logic c, input logic iv, input int x, input int y);
        if (c) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic all_same;
                m_p[k] = 1'b0;
                if (m_raw_vld) begin
                    for (int i = 15; i > 0; i--) m_h[k][i] = m_h[k][i-1];
                    m_h[k][0] = m_raw;
                    if (m_hn[k] < 16) m_hn[k]++;
                    all_same = (m_hn[k] >= nlen(k));
                    for (int i = 0; i < nlen(k); i++)
                        if (i < m_hn[k] && m_h[k][i] != m_raw) all_same = 1'b0;
                    if (all_same && m_raw != m_st[k]) begin
                        m_st[k] = m_raw;
                        m_p[k]  = 1'b1;
                        if (m_ev[k] < 255) m_ev[k]++;
                    end
                end
            end
            if (iv) begin
                m_raw = rel_of(x, y);
                m_raw_vld = 1'b1;
            end else begin
                m_raw_vld = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic iv, input int x, input int y);
        clr = c; in_valid = iv; a = 4'(x); b = 4'(y);
        @(posedge clk);
        model_edge(c, iv, x, y);
        #1;
        chk("m_st0",  st0,  m_st[0]);
        chk("m_raw0", raw0, m_raw);
        chk("m_p0",   p0,   m_p[0]);
        chk("m_st1",  st1,  m_st[1]);
        chk("m_raw1", raw1, m_raw);
        chk("m_p1",   p1,   m_p[1]);
`ifdef MAGCMP_DBNC_EVTCNT_EN
        chk("m_ev0", ev0, m_ev[0]);
        chk("m_ev1", ev1, m_ev[1]);
`endif
        $display("[TB] step clr=%0d iv=%0d a=%0d b=%0d -> st0=%0d raw0=%0d p0=%0d st1=%0d p1=%0d",
                 c, iv, x, y, st0, raw0, p0, st1, p1);
    endtask

    typedef struct {
        logic       c;
        logic       iv;
        int         x;
        int         y;
        logic [1:0] es;
        logic [1:0] er;
        logic       ep;
    } vec_t;

    vec_t tbl[27];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev_rel;
        // UNK=0 EQ=1 GT=2 LT=3; expectations for the DBNC_LEN=3 instance
        tbl[0]  = '{0,1, 5,5, 0,1,0}; tbl[1]  = '{0,1, 5,5, 0,1,0};
        tbl[2]  = '{0,1, 5,5, 0,1,0}; tbl[3]  = '{0,1, 5,5, 1,1,1};
        tbl[4]  = '{0,0, 0,0, 1,1,0}; tbl[5]  = '{0,1,12,7, 1,2,0};
        tbl[6]  = '{0,1,12,7, 1,2,0}; tbl[7]  = '{0,1, 3,9, 1,3,0};
        tbl[8]  = '{0,1, 3,9, 1,3,0}; tbl[9]  = '{0,1, 3,9, 1,3,0};
        tbl[10] = '{0,0, 0,0, 3,3,1}; tbl[11] = '{0,0, 0,0, 3,3,0};
        tbl[12] = '{0,1,15,0, 3,2,0}; tbl[13] = '{0,0, 0,0, 3,2,0};
        tbl[14] = '{0,0, 0,0, 3,2,0}; tbl[15] = '{0,1,15,0, 3,2,0};
        tbl[16] = '{0,0, 0,0, 3,2,0}; tbl[17] = '{0,0, 0,0, 3,2,0};
        tbl[18] = '{0,1,15,0, 3,2,0}; tbl[19] = '{0,0, 0,0, 2,2,1};
        tbl[20] = '{0,0, 0,0, 2,2,0}; tbl[21] = '{1,1, 0,15, 0,0,0};
        tbl[22] = '{0,1, 0,15, 0,3,0}; tbl[23] = '{0,1, 0,15, 0,3,0};
        tbl[24] = '{0,1, 0,15, 0,3,0}; tbl[25] = '{0,0, 0,0, 3,3,1};
        tbl[26] = '{0,0, 0,0, 3,3,0};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_st0", st0, REL_UNK);
        chk("rst_raw0", raw0, REL_UNK);
        chk("rst_p0", p0, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].c, tbl[i].iv, tbl[i].x, tbl[i].y);
            chk($sformatf("tbl%0d_st", i),  st0,  tbl[i].es);
            chk($sformatf("tbl%0d_raw", i), raw0, tbl[i].er);
            chk($sformatf("tbl%0d_p", i),   p0,   tbl[i].ep);
        end

        // Asynchronous reset mid-run while dut1 is pulsing
        step(0, 1, 5, 5);
        step(0, 1, 5, 5);
        chk("pre_rst_p1", p1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_st0", st0, REL_UNK);
        chk("async_raw0", raw0, REL_UNK);
        chk("async_st1", st1, REL_UNK);
        chk("async_p1", p1, 0);
        model_reset();
        @(posedge clk); #1;
        chk("hold_rst_st1", st1, REL_UNK);
        @(negedge clk); rst = 1'b0;

        // After reset the partial run is gone: three fresh samples needed
        step(0, 1, 5, 5); step(0, 1, 5, 5); step(0, 1, 5, 5);
        chk("post_rst_wait_st0", st0, REL_UNK);
        step(0, 0, 0, 0);
        chk("post_rst_st0", st0, REL_EQ);
        chk("post_rst_p0", p0, 1);

        // Event counter: 4 changes on the DBNC_LEN=1 instance, then saturation
        step(1, 0, 0, 0);
        step(0, 1, 5, 5); step(0, 1, 12, 7); step(0, 1, 5, 5); step(0, 1, 12, 7);
        step(0, 0, 0, 0);
`ifdef MAGCMP_DBNC_EVTCNT_EN
        chk("evt4", ev1, 4);
`endif
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) step(0, 1, 5, 5);
            else            step(0, 1, 12, 7);
        end
`ifdef MAGCMP_DBNC_EVTCNT_EN
        chk("evt_sat", ev1, 255);
`endif

        // Randomized runs with gaps and occasional clears
        prev_rel = 1;
        for (int i = 0; i < 400; i++) begin
            logic c, iv;
            int x, y, r;
            c  = ($urandom_range(0, 40) == 0);
            iv = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 9) < 7) ? prev_rel : int'($urandom_range(1, 3));
            prev_rel = r;
            if (r == 1) begin
                x = $urandom_range(0, 15); y = x;
            end else if (r == 2) begin
                x = $urandom_range(1, 15); y = $urandom_range(0, x - 1);
            end else begin
                x = $urandom_range(0, 14); y = $urandom_range(x + 1, 15);
            end
            step(c, iv, x, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
